pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the RISC-V core, replacing the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic stage. Each instance carries one beat, made of a control bundle and a data bundle, between two pipeline stages. Flow control is a valid/ready handshake with an optional 2-entry skid buffer, so ready is registered and back-pressure does not ripple combinationally through the pipeline. A flush inserts a bubble whose data field is a configurable value (the RISC-V NOP by default) and whose control field is all zeros.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_entry.sv | 56 +++++
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the generic pipeline stage register
package pipe_pkg;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef logic [1:0] occ_t;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic occ_t state_occ(state_t s);
    return occ_t'(s);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one valid+ctrl+data holding register with load, clear and reset
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W      = 8,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(RV_NOP)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // An empty entry always holds the bubble, so its outputs need no masking.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      data_d  = BUBBLE_DATA;
    end else if (load_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= BUBBLE_DATA;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic valid/ready pipeline stage register with optional skid entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W      = 8,
  parameter int unsigned       DATA_W      = 32,
  parameter logic [DATA_W-1:0] BUBBLE_DATA = DATA_W'(RV_NOP),
  parameter bit                SKID        = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  state_t state_q, state_d;

  logic              push, pop;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] skid_data, main_data_in;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            // Only reachable with the skid entry; without it in_ready is low here.
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            main_clear = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ONE;
          end
        end
        default: begin
          state_d    = EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_data_in = main_from_skid ? skid_data : in_data;

  pipe_entry #(
    .CTRL_W      (CTRL_W),
    .DATA_W      (DATA_W),
    .BUBBLE_DATA (BUBBLE_DATA)
  ) u_main (
    .clk_i    (clk),
    .resetn_i (reset),
    .load_i   (main_load),
    .clear_i  (main_clear),
    .ctrl_i   (main_ctrl_in),
    .data_i   (main_data_in),
    .valid_o  (out_valid),
    .ctrl_o   (out_ctrl),
    .data_o   (out_data)
  );

  generate
    if (SKID) begin : g_skid
      logic in_ready_q, in_ready_d;

      pipe_entry #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .BUBBLE_DATA (BUBBLE_DATA)
      ) u_skid (
        .clk_i    (clk),
        .resetn_i (reset),
        .load_i   (skid_load),
        .clear_i  (skid_clear),
        .ctrl_i   (in_ctrl),
        .data_i   (in_data),
        .valid_o  (skid_valid),
        .ctrl_o   (skid_ctrl),
        .data_o   (skid_data)
      );

      // Ready is the registered complement of next-cycle skid occupancy.
      assign in_ready_d = ~(skid_load | (skid_valid & ~skid_clear));

      always_ff @(posedge clk) begin
        if (!reset) begin
          in_ready_q <= 1'b0;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = BUBBLE_DATA;
      assign in_ready   = reset & (~out_valid | out_ready);
    end
  endgenerate

  assign occ = state_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (skid and no-skid builds)
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, in_valid, out_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occ;

  logic        flush0, in_valid0, out_ready0;
  logic [7:0]  in_ctrl0;
  logic [31:0] in_data0;
  logic        in_ready0, out_valid0;
  logic [7:0]  out_ctrl0;
  logic [31:0] out_data0;
  logic [1:0]  occ0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ(occ)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occ(occ0)
  );

  typedef struct {
    logic        iv;
    logic [7:0]  ic;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [7:0]  e_oc;
    logic [31:0] e_od;
    logic        e_ir;
    logic [1:0]  e_occ;
  } vec_t;

  function automatic vec_t mk(logic iv, logic [7:0] ic, logic [31:0] id, logic ordy, logic fl,
                              logic e_ov, logic [7:0] e_oc, logic [31:0] e_od, logic e_ir,
                              logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ov, input logic [7:0] e_oc,
                         input logic [31:0] e_od, input logic e_ir, input logic [1:0] e_occ);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
    chk({tag, ".out_ctrl"},  {24'd0, out_ctrl},  {24'd0, e_oc});
    chk({tag, ".out_data"},  out_data, e_od);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
    chk({tag, ".occ"},       {30'd0, occ},       {30'd0, e_occ});
  endtask

  vec_t vt[18];

  logic [31:0] sb[$];
  logic [31:0] seq_id;
  logic        r_push, r_pop;

  initial begin
    vt[0]  = mk(1, 8'h01, 32'h10, 1, 0,  1, 8'h01, 32'h10, 1, 2'd1);
    vt[1]  = mk(1, 8'h02, 32'h20, 1, 0,  1, 8'h02, 32'h20, 1, 2'd1);
    vt[2]  = mk(1, 8'h03, 32'h30, 1, 0,  1, 8'h03, 32'h30, 1, 2'd1);
    vt[3]  = mk(0, 8'h00, 32'h00, 1, 0,  0, 8'h00, NOP,    1, 2'd0);
    vt[4]  = mk(1, 8'h11, 32'hA1, 0, 0,  1, 8'h11, 32'hA1, 1, 2'd1);
    vt[5]  = mk(1, 8'h12, 32'hA2, 0, 0,  1, 8'h11, 32'hA1, 0, 2'd2);
    vt[6]  = mk(1, 8'h1F, 32'hFF, 0, 0,  1, 8'h11, 32'hA1, 0, 2'd2);
    vt[7]  = mk(0, 8'h00, 32'h00, 1, 0,  1, 8'h12, 32'hA2, 1, 2'd1);
    vt[8]  = mk(0, 8'h00, 32'h00, 1, 0,  0, 8'h00, NOP,    1, 2'd0);
    vt[9]  = mk(1, 8'h21, 32'hC1, 0, 0,  1, 8'h21, 32'hC1, 1, 2'd1);
    vt[10] = mk(1, 8'h22, 32'hC2, 0, 0,  1, 8'h21, 32'hC1, 0, 2'd2);
    vt[11] = mk(1, 8'hB0, 32'hB0, 0, 1,  0, 8'h00, NOP,    1, 2'd0);
    vt[12] = mk(0, 8'h00, 32'h00, 1, 0,  0, 8'h00, NOP,    1, 2'd0);
    vt[13] = mk(1, 8'h31, 32'hD1, 1, 0,  1, 8'h31, 32'hD1, 1, 2'd1);
    vt[14] = mk(1, 8'h32, 32'hD2, 1, 1,  0, 8'h00, NOP,    1, 2'd0);
    vt[15] = mk(1, 8'h33, 32'hD3, 0, 0,  1, 8'h33, 32'hD3, 1, 2'd1);
    vt[16] = mk(0, 8'h00, 32'h00, 0, 0,  1, 8'h33, 32'hD3, 1, 2'd1);
    vt[17] = mk(0, 8'h00, 32'h00, 1, 0,  0, 8'h00, NOP,    1, 2'd0);

    reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 32'h55;
    out_ready = 1'b1;
    flush0 = 1'b0; in_valid0 = 1'b1; in_ctrl0 = 8'h5A; in_data0 = 32'h55; out_ready0 = 1'b0;

    // Reset held three cycles with a beat offered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("reset%0d", i), 1'b0, 8'h00, NOP, 1'b0, 2'd0);
      chk($sformatf("reset%0d.in_ready0", i), {31'd0, in_ready0}, 32'd0);
      chk($sformatf("reset%0d.out_valid0", i), {31'd0, out_valid0}, 32'd0);
    end
    in_valid = 1'b0; in_valid0 = 1'b0; out_ready0 = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk_all("release", 1'b0, 8'h00, NOP, 1'b1, 2'd0);
    chk("release.in_ready0", {31'd0, in_ready0}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      in_valid = vt[i].iv; in_ctrl = vt[i].ic; in_data = vt[i].id;
      out_ready = vt[i].ordy; flush = vt[i].fl;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i].e_ov, vt[i].e_oc, vt[i].e_od, vt[i].e_ir, vt[i].e_occ);
    end
    flush = 1'b0;

    // Reset mid-transfer with both entries full.
    in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 8'h41; in_data = 32'hE1;
    @(negedge clk);
    in_ctrl = 8'h42; in_data = 32'hE2;
    @(negedge clk);
    chk("midrst.pre_occ", {30'd0, occ}, 32'd2);
    reset = 1'b0;
    @(negedge clk);
    chk_all("midrst", 1'b0, 8'h00, NOP, 1'b0, 2'd0);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_all("midrst_rel", 1'b0, 8'h00, NOP, 1'b1, 2'd0);

    // No-skid build: combinational ready and push-with-pop replacement.
    in_valid0 = 1'b1; in_ctrl0 = 8'h61; in_data0 = 32'hE1; out_ready0 = 1'b0;
    @(negedge clk);
    chk("s0.out_data", out_data0, 32'hE1);
    chk("s0.occ", {30'd0, occ0}, 32'd1);
    in_ctrl0 = 8'h62; in_data0 = 32'hE2;
    #1;
    chk("s0.stall_ready", {31'd0, in_ready0}, 32'd0);
    out_ready0 = 1'b1;
    #1;
    chk("s0.pop_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    chk("s0.replace_data", out_data0, 32'hE2);
    chk("s0.replace_ctrl", {24'd0, out_ctrl0}, 32'h62);
    chk("s0.replace_occ", {30'd0, occ0}, 32'd1);
    in_valid0 = 1'b0;
    @(negedge clk);
    chk("s0.drain_valid", {31'd0, out_valid0}, 32'd0);
    chk("s0.drain_data", out_data0, NOP);

    // Random traffic against a FIFO scoreboard.
    sb.delete();
    seq_id = 32'h1000;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 9) == 0);
      in_data   = seq_id;
      in_ctrl   = seq_id[7:0] ^ 8'hA5;
      r_push = in_valid & in_ready;
      r_pop  = out_valid & out_ready;
      if (r_pop) sb.pop_front();
      if (flush) sb.delete();
      else if (r_push) begin
        sb.push_back(seq_id);
        seq_id = seq_id + 1;
      end
      @(negedge clk);
      chk("rnd.occ", {30'd0, occ}, sb.size());
      if (sb.size() != 0) begin
        chk("rnd.valid", {31'd0, out_valid}, 32'd1);
        chk("rnd.head_data", out_data, sb[0]);
        chk("rnd.head_ctrl", {24'd0, out_ctrl}, {24'd0, sb[0][7:0] ^ 8'hA5});
      end else begin
        chk("rnd.valid", {31'd0, out_valid}, 32'd0);
        chk("rnd.bubble_data", out_data, NOP);
        chk("rnd.bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
      end
      chk("rnd.ready", {31'd0, in_ready}, {31'd0, (sb.size() < 2)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
